// File: rtl/dist_pkg.sv
// Shared defaults and reader state encoding for the distance/adjacency bank reader.
package dist_pkg;

  localparam int DEF_D          = 256;
  localparam int DEF_BW         = 1;
  localparam int DEF_ADDR_SPACE = 16;
  localparam int DEF_CNT_W      = 17;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int POPW           = $clog2(DEF_D * DEF_BW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/dist_bank_reader_if.sv
// Reader control, bank read port and output row stream; master is the reader side.
// out_popcnt exists only when DIST_READER_POPCNT_EN is defined.
interface dist_bank_reader_if
  import dist_pkg::*;
#(
  parameter int D          = DEF_D,
  parameter int BW         = DEF_BW,
  parameter int ADDR_SPACE = DEF_ADDR_SPACE,
  parameter int CNT_W      = DEF_CNT_W
);

  logic                  start;
  logic [ADDR_SPACE-1:0] base_addr;
  logic [CNT_W-1:0]      num_rows;
  logic                  busy;
  logic                  done;
  logic [ADDR_SPACE-1:0] raddr;
  logic [D*BW-1:0]       rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [D*BW-1:0]       out_data;
  logic [CNT_W-1:0]      out_idx;
  logic                  out_last;
`ifdef DIST_READER_POPCNT_EN
  logic [$clog2(D*BW+1)-1:0] out_popcnt;

  modport master (
    input  start, base_addr, num_rows, rdata, out_ready,
    output busy, done, raddr, out_valid, out_data, out_idx, out_last, out_popcnt
  );
  modport slave (
    output start, base_addr, num_rows, rdata, out_ready,
    input  busy, done, raddr, out_valid, out_data, out_idx, out_last, out_popcnt
  );
`else
  modport master (
    input  start, base_addr, num_rows, rdata, out_ready,
    output busy, done, raddr, out_valid, out_data, out_idx, out_last
  );
  modport slave (
    output start, base_addr, num_rows, rdata, out_ready,
    input  busy, done, raddr, out_valid, out_data, out_idx, out_last
  );
`endif

endinterface

// File: rtl/dist_rd_fifo.sv
// Synchronous row FIFO with occupancy count; head is read combinationally from flops.
// Head reads as zero while empty so the stream outputs rest at zero.
module dist_rd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign head_vld = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && head_vld;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked until an entry is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dist_bank_reader.sv
// Walks num_rows bank rows from base_addr; first row out 3 cycles after start, then 1/cycle.
// Credit issue never overruns the FIFO under backpressure; DIST_READER_POPCNT_EN adds out_popcnt.
module dist_bank_reader
  import dist_pkg::*;
#(
  parameter int D          = DEF_D,
  parameter int BW         = DEF_BW,
  parameter int ADDR_SPACE = DEF_ADDR_SPACE,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  dist_bank_reader_if.master bus
);

  localparam int DW = D * BW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef DIST_READER_POPCNT_EN
  localparam int POPC_W = $clog2(DW + 1);
  localparam int PW     = POPC_W + 1 + CNT_W + DW;
`else
  localparam int PW     = 1 + CNT_W + DW;
`endif

  rd_state_e             state;
  logic [ADDR_SPACE-1:0] rd_ptr;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      rows_q;
  logic                  inflight;
  logic [CNT_W-1:0]      infl_idx;
  logic                  infl_last;

  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic                  issue;
  logic                  issue_last;
  logic                  head_vld;
  logic                  pop;
  logic [PW-1:0]         push_dat;
  logic [PW-1:0]         head_dat;

  // A row in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue       = (state == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign issue_last  = (issue_cnt == rows_q - CNT_W'(1));
  assign pop         = head_vld && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      issue_cnt <= '0;
      rows_q    <= '0;
      inflight  <= 1'b0;
      infl_idx  <= '0;
      infl_last <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_idx  <= issue_cnt;
        infl_last <= issue_last;
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_rows == '0) begin
              state <= DONE;
            end else begin
              state     <= RUN;
              rd_ptr    <= bus.base_addr;
              rows_q    <= bus.num_rows;
              issue_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (issue) begin
            rd_ptr    <= rd_ptr + 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight && pop && bus.out_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIST_READER_POPCNT_EN
  assign push_dat = {POPC_W'($countones(bus.rdata)), infl_last, infl_idx, bus.rdata};
`else
  assign push_dat = {infl_last, infl_idx, bus.rdata};
`endif

  dist_rd_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_dat (push_dat),
    .pop      (pop),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.raddr     = rd_ptr;
  assign bus.out_valid = head_vld;
  assign bus.out_data  = head_dat[DW-1:0];
  assign bus.out_idx   = head_dat[DW +: CNT_W];
  assign bus.out_last  = head_dat[DW + CNT_W];
`ifdef DIST_READER_POPCNT_EN
  assign bus.out_popcnt = head_dat[DW + CNT_W + 1 +: POPC_W];
`endif

endmodule

// File: doc/dist_bank_reader.md
# dist_bank_reader

Streaming read front-end for the distance/adjacency bank SRAM. It sits directly downstream of the bank. Given a base address and a row count, it walks consecutive rows and drives the bank's read address. It absorbs the bank's one-cycle registered read latency and presents each D·BW-bit row on a valid/ready stream to the graph compute stage. An internal FIFO with credit-based issue sustains one row per cycle and tolerates arbitrary backpressure without losing rows.

## Interface
- D, 256, entries per bank row
- BW, 1, bits per entry
- ADDR_SPACE, 16, bank address width
- CNT_W, 17, row-count width (up to 2^16 rows)
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥4)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_SPACE  first row address, sampled with start
- num_rows  in  CNT_W  rows to read, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- raddr  out  ADDR_SPACE  to bank raddr
- rdata  in  D*BW  from bank rdata, valid the cycle after raddr is presented
- out_valid  out  1  row available
- out_ready  in  1  consumer accepts
- out_data  out  D*BW  row contents
- out_idx  out  CNT_W  row offset from base_addr (0-based)
- out_last  out  1  final row of the request
- out_popcnt  out  $clog2(D*BW+1)  set-bit count of out_data (present only with DIST_READER_POPCNT_EN)

## Operation
- FSM states:
  - IDLE: start → RUN, latching base and count.
  - IDLE: start with num_rows==0 → DONE.
  - RUN: last row issued → DRAIN.
  - DRAIN: FIFO empty, no read in flight, and last row handshaken → DONE.
  - DONE: → IDLE unconditionally.
- done is high in DONE only. busy is high in RUN and DRAIN.
- Issue: in RUN, issue a read when fifo_count + inflight < FIFO_DEPTH.
  - raddr = rd_ptr during the issue cycle; rd_ptr and issue_cnt increment at the edge.
  - inflight is the 1-bit registered issue flag.
- Capture: rdata is written into the FIFO at the end of the cycle following issue, tagged with idx and last.
- Pop: out_valid && out_ready.
- Simultaneous push and pop in one cycle: count is unchanged.
- rd_ptr wraps modulo 2^ADDR_SPACE. out_idx does not wrap.
- start while busy or in DONE is ignored.
- Reset mid-operation: FSM → IDLE and FIFO flushed. Rows still in flight are discarded.
- Reset values: busy 0, done 0, raddr 0, out_valid 0, out_data 0, out_idx 0, out_last 0, out_popcnt 0.

## Timing
- Cycle 0: start is sampled.
- Cycle 1: RUN; raddr = base.
- Cycle 2: bank rdata is valid and captured at end of cycle.
- Cycle 3: out_valid = 1 for row 0.
- With out_ready held high, there is one row per cycle thereafter with no bubbles.
- done pulses the cycle after the out_last handshake.
- num_rows==0: done pulses in cycle 1; raddr is not advanced.
- out_valid, out_data, out_idx, out_last and out_popcnt are registered (FIFO head) and hold stable while out_valid && !out_ready.

## Configuration
- DIST_READER_POPCNT_EN defined:
  - Popcount of rdata is computed at capture and stored per FIFO entry.
  - out_popcnt is aligned with out_data.
- DIST_READER_POPCNT_EN undefined: the out_popcnt port and all popcount logic are absent. Stream timing is identical in both builds.

## Structure
- Package dist_pkg holds:
  - default D, BW, ADDR_SPACE.
  - POPW = $clog2(D*BW+1).
  - the reader state enum typedef (IDLE, RUN, DRAIN, DONE).
- One sub-module: dist_rd_fifo.
  - Synchronous FIFO, parameterised width and depth, with count output.
  - Carries data, idx, last and optional popcnt.

## Test plan
- Basic stream: base 0x0010, num_rows 5, out_ready=1, bank rows preloaded with idx pattern.
  - Expect raddr 0x0010–0x0014 on cycles 1–5.
  - out_valid cycles 3–7, out_last on idx 4, done in cycle 8.
- Backpressure: num_rows 8, out_ready toggling 1/0 then held low 10 cycles.
  - Expect no lost or duplicated rows and issue stalled at 4 buffered.
  - Outputs stable while stalled.
- Wrap: base 0xFFFE, num_rows 4.
  - Expect raddr FFFE, FFFF, 0000, 0001 and out_idx 0–3.
- Zero count and ignored start: num_rows 0 → done in cycle 1 with no out_valid. A start pulsed mid-RUN has no effect.
- Reset mid-operation: rst_n low at row 3 of 10.
  - Outputs are at reset values immediately.
  - A new start of 2 rows completes correctly.
- Popcount (DIST_READER_POPCNT_EN): rows of all-ones, zero, and a single bit.
  - Expect out_popcnt 256, 0, 1.
